text_console_ctrl: RTL and testbench

TEXT_CONSOLE_CTRL -- requirements
Module: text_console_ctrl

---
 rtl/text_console_pkg.sv | 26 ++
 rtl/cell_addr_gen.sv | 26 ++
 rtl/text_console_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_text_console_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_console_pkg.sv
// rtl/text_console_pkg.sv - shared types and constants for the text console controller
//
// Contents:
//   state_t         controller FSM states (IDLE, WRITE, CLEAR)
//   CODE_*          control-code values recognised on the character stream
//   COLS_DEFAULT    default characters per row
//   ROWS_DEFAULT    default rows per screen

package text_console_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic [7:0] CODE_BS        = 8'h08;
    localparam logic [7:0] CODE_LF        = 8'h0A;
    localparam logic [7:0] CODE_FF        = 8'h0C;
    localparam logic [7:0] CODE_CR        = 8'h0D;
    localparam logic [7:0] CODE_PRINT_MIN = 8'h20;

    localparam int COLS_DEFAULT = 80;
    localparam int ROWS_DEFAULT = 60;

endpackage

// File: rtl/cell_addr_gen.sv
// rtl/cell_addr_gen.sv - maps a (row, col) cursor position to a text-RAM word and byte lane
//
// Ports:
//   row        in   6   cursor row
//   col        in   7   cursor column
//   word_addr  out  32  word address of the cell
//   byte_en    out  4   one-hot lane of the cell within the word (lane 0 = bits 7:0)

module cell_addr_gen
    import text_console_pkg::*;
#(
    parameter int COLS      = COLS_DEFAULT,
    parameter int BASE_WORD = 0
) (
    input  logic [5:0]  row,
    input  logic [6:0]  col,
    output logic [31:0] word_addr,
    output logic [3:0]  byte_en
);

    // COLS is a multiple of 4, so every row starts on a word boundary and
    // (row*COLS + col)/4 reduces to row*(COLS/4) + col/4.
    assign word_addr = 32'(BASE_WORD) + 32'(row) * 32'(COLS / 4) + 32'(col[6:2]);
    assign byte_en   = 4'b0001 << col[1:0];

endmodule

// File: rtl/text_console_ctrl.sv
// rtl/text_console_ctrl.sv - character-stream to text-RAM console controller
//
// Optional feature: define CONSOLE_BACKSPACE_EN to make 0x08 erase the cell left of the cursor.
//
// Ports:
//   clk         in   1   clock, rising edge
//   rst         in   1   asynchronous active-high reset
//   char_in     in   8   character code
//   char_valid  in   1   char_in is valid
//   char_ready  out  1   character accepted this cycle when char_valid is high
//   clear_req   in   1   single-cycle request to blank the screen
//   Address     out  32  text-RAM word address
//   mem_wdata   out  32  write data
//   mem_be      out  4   byte enables
//   mem_we      out  1   write strobe
//   busy        out  1   high whenever not IDLE
//   cursor_col  out  7   current column
//   cursor_row  out  6   current row

module text_console_ctrl
    import text_console_pkg::*;
#(
    parameter int COLS      = COLS_DEFAULT,
    parameter int ROWS      = ROWS_DEFAULT,
    parameter int BASE_WORD = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    input  logic        clear_req,
    output logic [31:0] Address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_we,
    output logic        busy,
    output logic [6:0]  cursor_col,
    output logic [5:0]  cursor_row
);

    localparam int WORDS = ROWS * COLS / 4;

`ifdef CONSOLE_BACKSPACE_EN
    localparam bit BS_EN = 1'b1;
`else
    localparam bit BS_EN = 1'b0;
`endif

    state_t      state, state_next;
    logic [6:0]  col, col_next;
    logic [5:0]  row, row_next;
    logic [31:0] clr_cnt, clr_next;
    logic [7:0]  wr_char, char_next;
    logic        wr_adv, adv_next;

    logic [31:0] cell_word;
    logic [3:0]  cell_be;
    logic        col_last, row_last;
    logic [5:0]  row_inc;
    logic        we_c;
    logic [31:0] addr_c, wdata_c;
    logic [3:0]  be_c;

    cell_addr_gen #(
        .COLS      (COLS),
        .BASE_WORD (BASE_WORD)
    ) u_cell_addr (
        .row       (row),
        .col       (col),
        .word_addr (cell_word),
        .byte_en   (cell_be)
    );

    assign col_last = (col == 7'(COLS - 1));
    assign row_last = (row == 6'(ROWS - 1));
    assign row_inc  = row_last ? 6'd0 : row + 6'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col     <= '0;
            row     <= '0;
            clr_cnt <= '0;
            wr_char <= '0;
            wr_adv  <= 1'b0;
        end else begin
            col     <= col_next;
            row     <= row_next;
            clr_cnt <= clr_next;
            wr_char <= char_next;
            wr_adv  <= adv_next;
        end
    end

    always_comb begin
        state_next = state;
        col_next   = col;
        row_next   = row;
        clr_next   = clr_cnt;
        char_next  = wr_char;
        adv_next   = wr_adv;
        we_c       = 1'b0;
        addr_c     = '0;
        wdata_c    = '0;
        be_c       = '0;

        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next = CLEAR;
                    clr_next   = '0;
                end else if (char_valid) begin
                    if (char_in >= CODE_PRINT_MIN) begin
                        state_next = WRITE;
                        char_next  = char_in;
                        adv_next   = 1'b1;
                    end else if (char_in == CODE_LF) begin
                        col_next = '0;
                        row_next = row_inc;
                    end else if (char_in == CODE_CR) begin
                        col_next = '0;
                    end else if (char_in == CODE_FF) begin
                        state_next = CLEAR;
                        clr_next   = '0;
                    end else if (BS_EN && char_in == CODE_BS && col != 7'd0) begin
                        // Step back first so WRITE blanks the cell now under the cursor.
                        state_next = WRITE;
                        col_next   = col - 7'd1;
                        char_next  = 8'h00;
                        adv_next   = 1'b0;
                    end
                end
            end

            WRITE: begin
                we_c       = 1'b1;
                addr_c     = cell_word;
                wdata_c    = {4{wr_char}};
                be_c       = cell_be;
                state_next = IDLE;
                if (wr_adv) begin
                    if (col_last) begin
                        col_next = '0;
                        row_next = row_inc;
                    end else begin
                        col_next = col + 7'd1;
                    end
                end
            end

            CLEAR: begin
                we_c    = 1'b1;
                addr_c  = 32'(BASE_WORD) + clr_cnt;
                wdata_c = '0;
                be_c    = 4'b1111;
                if (clr_cnt == 32'(WORDS - 1)) begin
                    state_next = IDLE;
                    clr_next   = '0;
                    col_next   = '0;
                    row_next   = '0;
                end else begin
                    clr_next = clr_cnt + 32'd1;
                end
            end

            default: begin
                state_next = CLEAR;
                clr_next   = '0;
            end
        endcase
    end

    // The state register sits in CLEAR while rst is held; keep the strobe quiet until release.
    assign mem_we     = we_c & ~rst;
    assign Address    = addr_c;
    assign mem_wdata  = wdata_c;
    assign mem_be     = be_c;
    assign busy       = (state != IDLE);
    assign char_ready = (state == IDLE) && !clear_req;
    assign cursor_col = col;
    assign cursor_row = row;

endmodule

// File: tb/tb_text_console_ctrl.sv
// tb/tb_text_console_ctrl.sv - self-checking bench for text_console_ctrl

module tb_text_console_ctrl;

    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int CELLS = COLS * ROWS;
    localparam int WORDS = CELLS / 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  char_in = 8'h00;
    logic        char_valid = 1'b0;
    logic        clear_req = 1'b0;
    logic        char_ready;
    logic [31:0] Address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_we;
    logic        busy;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;

    int checks = 0;
    int failures = 0;

    text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .BASE_WORD(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .clear_req  (clear_req),
        .Address    (Address),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_we     (mem_we),
        .busy       (busy),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    always #5 clk = ~clk;

    // Observed text RAM, built from the write strobes.
    logic [31:0] vram [WORDS];
    int          wr_count = 0;
    int          oob_count = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_be = '0;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_count++;
            last_addr  = Address;
            last_wdata = mem_wdata;
            last_be    = mem_be;
            if (Address < WORDS) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) vram[Address][8*b +: 8] = mem_wdata[8*b +: 8];
            end else begin
                oob_count++;
            end
        end
    end

    // Reference model: screen as a flat array of character cells plus a cursor.
    logic [7:0]  scr [CELLS];
    int          mr = 0;
    int          mc = 0;
    bit          exp_we;
    int          exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_data;

    task automatic model_clear();
        foreach (scr[i]) scr[i] = 8'h00;
        mr = 0;
        mc = 0;
    endtask

    task automatic model_expect_write(input int idx, input logic [7:0] c);
        scr[idx] = c;
        exp_we   = 1'b1;
        exp_addr = idx / 4;
        exp_be   = 4'(1 << (idx % 4));
        exp_data = {4{c}};
    endtask

    task automatic model_char(input logic [7:0] c);
        exp_we = 1'b0;
        if (c >= 8'h20) begin
            model_expect_write(mr * COLS + mc, c);
            mc++;
            if (mc == COLS) begin
                mc = 0;
                mr = (mr + 1) % ROWS;
            end
        end else if (c == 8'h0A) begin
            mc = 0;
            mr = (mr + 1) % ROWS;
        end else if (c == 8'h0D) begin
            mc = 0;
        end else if (c == 8'h0C) begin
            model_clear();
        end
`ifdef CONSOLE_BACKSPACE_EN
        else if (c == 8'h08 && mc > 0) begin
            mc--;
            model_expect_write(mr * COLS + mc, 8'h00);
        end
`endif
    endtask

    function automatic int vram_diff();
        int n = 0;
        for (int w = 0; w < WORDS; w++)
            if (vram[w] !== {scr[4*w+3], scr[4*w+2], scr[4*w+1], scr[4*w]}) n++;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_char(input logic [7:0] c);
        int n = 0;
        while (char_ready !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (char_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_timeout: char_ready=%b after %0d cycles, required 1", char_ready, n);
        end
        char_in    = c;
        char_valid = 1'b1;
        tick();
        char_valid = 1'b0;
        model_char(c);
        tick();
    endtask

    task automatic goto(input int r, input int c);
        send_char(8'h0D);
        while (mr != r) send_char(8'h0A);
        while (mc != c) send_char(8'($urandom_range(32, 255)));
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 5000) begin
            clear_req = (n == 600);
            tick();
            n++;
        end
        clear_req = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        foreach (vram[i]) vram[i] = 32'hDEADBEEF;
        repeat (3) tick();
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b required 0", mem_we); end
        checks++; if (char_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b required 0", char_ready); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy: got %b required 1", busy); end
        checks++; if (cursor_row !== 6'd0 || cursor_col !== 7'd0) begin failures++; $display("FAIL reset_cursor: got (%0d,%0d) required (0,0)", cursor_row, cursor_col); end
        wr_count  = 0;
        oob_count = 0;
        rst = 1'b0;
        model_clear();
        wait_idle(n);
        checks++; if (n != WORDS) begin failures++; $display("FAIL reset_busy_len: got %0d required %0d", n, WORDS); end
        checks++; if (wr_count != WORDS) begin failures++; $display("FAIL reset_writes: got %0d required %0d", wr_count, WORDS); end
        checks++; if (oob_count != 0) begin failures++; $display("FAIL reset_oob: got %0d required 0", oob_count); end
        checks++; if (vram_diff() != 0) begin failures++; $display("FAIL reset_vram: %0d words differ, required 0", vram_diff()); end
        checks++; if (cursor_row !== 6'd0 || cursor_col !== 7'd0) begin failures++; $display("FAIL reset_end_cursor: got (%0d,%0d) required (0,0)", cursor_row, cursor_col); end
        checks++; if (char_ready !== 1'b1) begin failures++; $display("FAIL reset_end_ready: got %b required 1", char_ready); end
    endtask

    task automatic test_write_char();
        int base;
        goto(0, 5);
        base = wr_count;
        send_char(8'h41);
        tick();
        checks++; if (wr_count - base != 1) begin failures++; $display("FAIL write_count: got %0d required 1", wr_count - base); end
        checks++; if (last_addr !== 32'(exp_addr)) begin failures++; $display("FAIL write_addr: got %0d required %0d", last_addr, exp_addr); end
        checks++; if (last_be !== exp_be) begin failures++; $display("FAIL write_be: got %b required %b", last_be, exp_be); end
        checks++; if (last_wdata !== exp_data) begin failures++; $display("FAIL write_data: got %h required %h", last_wdata, exp_data); end
        checks++; if (cursor_row !== 6'(mr) || cursor_col !== 7'(mc)) begin failures++; $display("FAIL write_cursor: got (%0d,%0d) required (%0d,%0d)", cursor_row, cursor_col, mr, mc); end
    endtask

    task automatic test_wrap();
        goto(ROWS - 1, COLS - 1);
        send_char(8'h5A);
        checks++; if (last_addr !== 32'(exp_addr)) begin failures++; $display("FAIL wrap_addr: got %0d required %0d", last_addr, exp_addr); end
        checks++; if (last_be !== exp_be) begin failures++; $display("FAIL wrap_be: got %b required %b", last_be, exp_be); end
        checks++; if (cursor_row !== 6'(mr) || cursor_col !== 7'(mc)) begin failures++; $display("FAIL wrap_cursor: got (%0d,%0d) required (%0d,%0d)", cursor_row, cursor_col, mr, mc); end
    endtask

    task automatic test_newline_cr();
        int base;
        goto(10, 33);
        base = wr_count;
        send_char(8'h0A);
        checks++; if (wr_count != base) begin failures++; $display("FAIL lf_nowrite: got %0d writes required 0", wr_count - base); end
        checks++; if (cursor_row !== 6'(mr) || cursor_col !== 7'(mc)) begin failures++; $display("FAIL lf_cursor: got (%0d,%0d) required (%0d,%0d)", cursor_row, cursor_col, mr, mc); end
        goto(11, 33);
        base = wr_count;
        send_char(8'h0D);
        checks++; if (wr_count != base) begin failures++; $display("FAIL cr_nowrite: got %0d writes required 0", wr_count - base); end
        checks++; if (cursor_row !== 6'(mr) || cursor_col !== 7'(mc)) begin failures++; $display("FAIL cr_cursor: got (%0d,%0d) required (%0d,%0d)", cursor_row, cursor_col, mr, mc); end
    endtask

    task automatic test_ctrl_codes();
        int base;
`ifdef CONSOLE_BACKSPACE_EN
        logic [7:0] codes [5] = '{8'h00, 8'h07, 8'h1B, 8'h1F, 8'h01};
`else
        logic [7:0] codes [5] = '{8'h00, 8'h07, 8'h1B, 8'h1F, 8'h08};
`endif
        goto(4, 9);
        foreach (codes[i]) begin
            base = wr_count;
            send_char(codes[i]);
            checks++; if (wr_count != base || cursor_row !== 6'(mr) || cursor_col !== 7'(mc)) begin failures++; $display("FAIL ctrl_%h: writes=%0d cursor (%0d,%0d), required 0 writes at (%0d,%0d)", codes[i], wr_count - base, cursor_row, cursor_col, mr, mc); end
        end
    endtask

`ifdef CONSOLE_BACKSPACE_EN
    task automatic test_backspace();
        int base;
        goto(2, 4);
        base = wr_count;
        send_char(8'h08);
        checks++; if (wr_count - base != 1) begin failures++; $display("FAIL bs_count: got %0d required 1", wr_count - base); end
        checks++; if (last_addr !== 32'(exp_addr) || last_be !== exp_be) begin failures++; $display("FAIL bs_addr: got %0d/%b required %0d/%b", last_addr, last_be, exp_addr, exp_be); end
        checks++; if (last_wdata !== 32'h0) begin failures++; $display("FAIL bs_data: got %h required 0", last_wdata); end
        checks++; if (cursor_row !== 6'(mr) || cursor_col !== 7'(mc)) begin failures++; $display("FAIL bs_cursor: got (%0d,%0d) required (%0d,%0d)", cursor_row, cursor_col, mr, mc); end
        goto(2, 0);
        base = wr_count;
        send_char(8'h08);
        checks++; if (wr_count != base || cursor_col !== 7'd0) begin failures++; $display("FAIL bs_col0: writes=%0d col=%0d required 0 writes col 0", wr_count - base, cursor_col); end
    endtask
`endif

    task automatic test_clear_ignored_in_write();
        goto(7, 7);
        char_in    = 8'h57;
        char_valid = 1'b1;
        tick();
        char_valid = 1'b0;
        model_char(8'h57);
        clear_req  = 1'b1;
        tick();
        clear_req  = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clr_in_write: busy=%b required 0", busy); end
        checks++; if (cursor_row !== 6'(mr) || cursor_col !== 7'(mc)) begin failures++; $display("FAIL clr_in_write_cursor: got (%0d,%0d) required (%0d,%0d)", cursor_row, cursor_col, mr, mc); end
    endtask

    task automatic test_clear_priority();
        int base, n;
        goto(5, 7);
        base       = wr_count;
        clear_req  = 1'b1;
        char_valid = 1'b1;
        char_in    = 8'h51;
        #1;
        checks++; if (char_ready !== 1'b0) begin failures++; $display("FAIL prio_ready: got %b required 0", char_ready); end
        tick();
        clear_req  = 1'b0;
        char_valid = 1'b0;
        model_clear();
        wait_idle(n);
        checks++; if (n != WORDS) begin failures++; $display("FAIL prio_busy_len: got %0d required %0d", n, WORDS); end
        checks++; if (wr_count - base != WORDS) begin failures++; $display("FAIL prio_writes: got %0d required %0d", wr_count - base, WORDS); end
        checks++; if (vram_diff() != 0) begin failures++; $display("FAIL prio_vram: %0d words differ, required 0", vram_diff()); end
        checks++; if (cursor_row !== 6'd0 || cursor_col !== 7'd0) begin failures++; $display("FAIL prio_cursor: got (%0d,%0d) required (0,0)", cursor_row, cursor_col); end
    endtask

    task automatic test_reset_midwrite();
        int base, n;
        goto(3, 3);
        char_in    = 8'h52;
        char_valid = 1'b1;
        tick();
        char_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0 || busy !== 1'b1 || cursor_col !== 7'd0) begin failures++; $display("FAIL midrst_state: we=%b busy=%b col=%0d required 0/1/0", mem_we, busy, cursor_col); end
        tick();
        rst  = 1'b0;
        base = wr_count;
        model_clear();
        wait_idle(n);
        checks++; if (n != WORDS || wr_count - base != WORDS) begin failures++; $display("FAIL midrst_clear: busy=%0d writes=%0d required %0d", n, wr_count - base, WORDS); end
        checks++; if (vram_diff() != 0) begin failures++; $display("FAIL midrst_vram: %0d words differ, required 0", vram_diff()); end
    endtask

    task automatic test_random();
        int base;
        logic [7:0] c;
        logic [7:0] ctl [6] = '{8'h0A, 8'h0D, 8'h08, 8'h00, 8'h1B, 8'h03};
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 9) < 7) c = 8'($urandom_range(32, 255));
            else c = ctl[$urandom_range(0, 5)];
            base = wr_count;
            send_char(c);
            checks++; if (wr_count - base != int'(exp_we)) begin failures++; $display("FAIL rand_count[%0d] code %h: got %0d required %0d", i, c, wr_count - base, exp_we); end
            if (exp_we) begin
                checks++; if (last_addr !== 32'(exp_addr) || last_be !== exp_be || last_wdata !== exp_data) begin failures++; $display("FAIL rand_write[%0d]: got %0d/%b/%h required %0d/%b/%h", i, last_addr, last_be, last_wdata, exp_addr, exp_be, exp_data); end
            end
            checks++; if (cursor_row !== 6'(mr) || cursor_col !== 7'(mc)) begin failures++; $display("FAIL rand_cursor[%0d]: got (%0d,%0d) required (%0d,%0d)", i, cursor_row, cursor_col, mr, mc); end
        end
        checks++; if (vram_diff() != 0) begin failures++; $display("FAIL rand_vram: %0d words differ, required 0", vram_diff()); end
    endtask

    initial begin
        test_reset();
        test_write_char();
        test_wrap();
        test_newline_cr();
        test_ctrl_codes();
`ifdef CONSOLE_BACKSPACE_EN
        test_backspace();
`endif
        test_clear_ignored_in_write();
        test_clear_priority();
        test_random();
        test_reset_midwrite();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
